commit_trace_buf: RTL and testbench

Parametrised commit-trace buffer placed beside the CPU top, consuming the per-cycle retire stream (`commit`, `commit_instr`, `commit_pc`, `commit_pre_pc`) and queueing it for a slower trace/difftest consumer over a valid/ready handshake. It adds what the raw commit port lacks:
- buffering of DEPTH entries,
- a per-entry sequence number,
- redirect (misprediction) detection against the previous commit's predicted PC,
- saturating drop accounting when the consumer stalls.

---
 rtl/commit_trace_buf.sv | 195 +++++++++++++++++++
 tb/tb_commit_trace_buf.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : commit_trace_buf
// Purpose  : Queues the CPU retire stream for a slower trace consumer. Each
//            entry is tagged with a sequence number and a redirect flag. Drops
//            are counted with saturation. Define TRACE_TIMESTAMP_EN to add
//            per-entry cycle timestamps on trace_ts.
// Revision : 1.0 - initial release
// ============================================================================
module commit_trace_buf #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32,
  parameter int TS_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     commit,
  input  logic [31:0]              commit_instr,
  input  logic [XLEN-1:0]          commit_pc,
  input  logic [XLEN-1:0]          commit_pre_pc,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [31:0]              trace_instr,
  output logic [XLEN-1:0]          trace_pc,
  output logic [XLEN-1:0]          trace_pre_pc,
  output logic [CNT_W-1:0]         trace_seq,
  output logic                     trace_redirect,
`ifdef TRACE_TIMESTAMP_EN
  output logic [TS_W-1:0]          trace_ts,
`endif
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         commit_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow
);

  localparam int               AW       = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
`ifdef TRACE_TIMESTAMP_EN
  localparam logic [TS_W-1:0]  TS_ONE   = {{(TS_W-1){1'b0}}, 1'b1};
`endif

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_bad_cfg
    $error("commit_trace_buf: DEPTH must be a power of two >= 2 and TS_W >= 1");
  end

  typedef struct packed {
    logic [31:0]      instr;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pre_pc;
    logic [CNT_W-1:0] seq;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]  ts;
`endif
    logic             redirect;
  } entry_t;

  entry_t mem_q [DEPTH];

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] commit_cnt_q, commit_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;
  logic             have_prev_q, have_prev_d;
  logic [XLEN-1:0]  prev_pre_pc_q, prev_pre_pc_d;
`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]  ts_q, ts_d;
`endif

  logic   full;
  logic   pop;
  logic   push;
  logic   drop;
  entry_t new_entry;
  entry_t head;

  // A pop frees its slot in the same cycle, so a push at full still lands.
  always_comb begin
    full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
           (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop  = valid_q && trace_ready && !clear;
    push = commit && !clear && (!full || pop);
    drop = commit && !clear && full && !pop;

    new_entry          = '0;
    new_entry.instr    = commit_instr;
    new_entry.pc       = commit_pc;
    new_entry.pre_pc   = commit_pre_pc;
    new_entry.seq      = commit_cnt_q;
    new_entry.redirect = have_prev_q && (commit_pc != prev_pre_pc_q);
`ifdef TRACE_TIMESTAMP_EN
    new_entry.ts       = ts_q;
`endif
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    commit_cnt_d  = commit_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    overflow_d    = overflow_q;
    have_prev_d   = have_prev_q;
    prev_pre_pc_d = prev_pre_pc_q;

    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      commit_cnt_d = '0;
      drop_cnt_d   = '0;
      overflow_d   = 1'b0;
      have_prev_d  = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      // Dropped commits still advance the count and the redirect reference.
      if (commit) begin
        commit_cnt_d  = commit_cnt_q + CNT_ONE;
        have_prev_d   = 1'b1;
        prev_pre_pc_d = commit_pre_pc;
      end
      if (drop) begin
        if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CNT_ONE;
        overflow_d = 1'b1;
      end
    end

    level_d = wr_ptr_d - rd_ptr_d;
    valid_d = (wr_ptr_d != rd_ptr_d);
  end

`ifdef TRACE_TIMESTAMP_EN
  always_comb begin
    ts_d = clear ? '0 : ts_q + TS_ONE;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      valid_q       <= 1'b0;
      commit_cnt_q  <= '0;
      drop_cnt_q    <= '0;
      overflow_q    <= 1'b0;
      have_prev_q   <= 1'b0;
      prev_pre_pc_q <= '0;
`ifdef TRACE_TIMESTAMP_EN
      ts_q          <= '0;
`endif
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      valid_q       <= valid_d;
      commit_cnt_q  <= commit_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      overflow_q    <= overflow_d;
      have_prev_q   <= have_prev_d;
      prev_pre_pc_q <= prev_pre_pc_d;
`ifdef TRACE_TIMESTAMP_EN
      ts_q          <= ts_d;
`endif
    end
  end

  // Storage needs no reset: slots are only observed between the pointers.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q[AW-1:0]] <= new_entry;
  end

  assign head           = mem_q[rd_ptr_q[AW-1:0]];
  assign trace_valid    = valid_q;
  assign trace_instr    = head.instr;
  assign trace_pc       = head.pc;
  assign trace_pre_pc   = head.pre_pc;
  assign trace_seq      = head.seq;
  assign trace_redirect = head.redirect;
`ifdef TRACE_TIMESTAMP_EN
  assign trace_ts       = head.ts;
`endif
  assign level          = level_q;
  assign commit_cnt     = commit_cnt_q;
  assign drop_cnt       = drop_cnt_q;
  assign overflow       = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_trace_buf
// Purpose  : Scoreboard bench for commit_trace_buf: directed scenarios plus a
//            randomized stream checked against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_commit_trace_buf;

  localparam int XLEN  = 64;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int TS_W  = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic              commit = 1'b0;
  logic [31:0]       commit_instr = '0;
  logic [XLEN-1:0]   commit_pc = '0;
  logic [XLEN-1:0]   commit_pre_pc = '0;
  logic              trace_ready = 1'b0;
  logic              trace_valid;
  logic [31:0]       trace_instr;
  logic [XLEN-1:0]   trace_pc;
  logic [XLEN-1:0]   trace_pre_pc;
  logic [CNT_W-1:0]  trace_seq;
  logic              trace_redirect;
`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]   trace_ts;
`endif
  logic [LW-1:0]     level;
  logic [CNT_W-1:0]  commit_cnt;
  logic [CNT_W-1:0]  drop_cnt;
  logic              overflow;

  commit_trace_buf #(
    .XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W), .TS_W(TS_W)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .commit(commit), .commit_instr(commit_instr),
    .commit_pc(commit_pc), .commit_pre_pc(commit_pre_pc),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_instr(trace_instr), .trace_pc(trace_pc),
    .trace_pre_pc(trace_pre_pc), .trace_seq(trace_seq),
    .trace_redirect(trace_redirect),
`ifdef TRACE_TIMESTAMP_EN
    .trace_ts(trace_ts),
`endif
    .level(level), .commit_cnt(commit_cnt),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      instr;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pre_pc;
    logic [CNT_W-1:0] seq;
    logic             redirect;
    logic [TS_W-1:0]  ts;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int               m_cnt;
  int unsigned      m_ccnt;
  int unsigned      m_dcnt;
  logic             m_ovf;
  logic             m_have;
  logic [XLEN-1:0]  m_prev;
  int unsigned      m_ts;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at each rising edge with the inputs that edge samples.
  task automatic model_step();
    exp_t e;
    logic pop;
    if (rst || clear) begin
      m_cnt = 0; m_ccnt = 0; m_dcnt = 0; m_ovf = 1'b0;
      m_have = 1'b0; m_prev = '0; m_ts = 0;
      exp_q.delete();
    end else begin
      pop = (m_cnt > 0) && trace_ready;
      if (commit) begin
        if (m_cnt < DEPTH || pop) begin
          e.instr    = commit_instr;
          e.pc       = commit_pc;
          e.pre_pc   = commit_pre_pc;
          e.seq      = CNT_W'(m_ccnt % (1 << CNT_W));
          e.redirect = m_have && (commit_pc != m_prev);
          e.ts       = TS_W'(m_ts % (1 << TS_W));
          exp_q.push_back(e);
          m_cnt++;
        end else begin
          if (m_dcnt < (1 << CNT_W) - 1) m_dcnt++;
          m_ovf = 1'b1;
        end
        m_ccnt++;
        m_have = 1'b1;
        m_prev = commit_pre_pc;
      end
      if (pop) m_cnt--;
      m_ts++;
    end
  endtask

  task automatic check_status();
    chk("trace_valid", XLEN'(trace_valid), XLEN'(m_cnt != 0));
    chk("level", XLEN'(level), XLEN'(m_cnt));
    chk("commit_cnt", XLEN'(commit_cnt), XLEN'(m_ccnt % (1 << CNT_W)));
    chk("drop_cnt", XLEN'(drop_cnt), XLEN'(m_dcnt));
    chk("overflow", XLEN'(overflow), XLEN'(m_ovf));
  endtask

  task automatic cyc(input logic c, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                     input logic [XLEN-1:0] pre, input logic rdy, input logic clr);
    commit = c; commit_instr = ins; commit_pc = pc; commit_pre_pc = pre;
    trace_ready = rdy; clear = clr;
    @(posedge clk);
    model_step();
    #1;
    check_status();
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, '0, '0, rdy, 1'b0);
  endtask

  task automatic do_clear();
    cyc(1'b0, 32'h0, '0, '0, 1'b0, 1'b1);
  endtask

  // Monitor: hands each consumed head entry to the scoreboard.
  always @(negedge clk) begin
    if (!rst && trace_valid === 1'b1 && trace_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_entry: got seq %0d, expected no entry (t=%0t)", trace_seq, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("entry_instr", XLEN'(trace_instr), XLEN'(e.instr));
        chk("entry_pc", trace_pc, e.pc);
        chk("entry_pre_pc", trace_pre_pc, e.pre_pc);
        chk("entry_seq", XLEN'(trace_seq), XLEN'(e.seq));
        chk("entry_redirect", XLEN'(trace_redirect), XLEN'(e.redirect));
`ifdef TRACE_TIMESTAMP_EN
        chk("entry_ts", XLEN'(trace_ts), XLEN'(e.ts));
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pre;
    logic [XLEN-1:0] next_pc;
    int              rdy_pct;

    // Reset
    rst = 1'b1;
    idle(1'b0, 3);
    rst = 1'b0;
    chk("reset_level", XLEN'(level), '0);
    chk("reset_valid", XLEN'(trace_valid), '0);

    // Basic in-order stream with ready held high
    pc = 64'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h0000_0013 + 32'(i), pc, pc + 64'd4, 1'b1, 1'b0);
      chk("basic_latency_valid", XLEN'(trace_valid), 64'd1);
      pc = pc + 64'd4;
    end
    idle(1'b1, 2);
    chk("basic_level", XLEN'(level), '0);
    chk("basic_commit_cnt", XLEN'(commit_cnt), 64'd3);

    // Redirect detection, including first commit after clear
    do_clear();
    cyc(1'b1, 32'h1111_1111, 64'h8000_0000, 64'h8000_0004, 1'b0, 1'b0);
    cyc(1'b1, 32'h2222_2222, 64'h8000_0100, 64'h8000_0104, 1'b0, 1'b0);
    chk("redirect_first", XLEN'(trace_redirect), '0);
    idle(1'b1, 3);
    do_clear();
    cyc(1'b1, 32'h3333_3333, 64'h1234_5678, 64'h1234_567c, 1'b0, 1'b0);
    chk("redirect_after_clear", XLEN'(trace_redirect), '0);
    idle(1'b1, 2);

    // Overflow with consumer stalled
    do_clear();
    pc = 64'h8000_0000;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 32'hA000_0000 + 32'(i), pc, pc + 64'd4, 1'b0, 1'b0);
      pc = pc + 64'd4;
    end
    chk("ovf_level", XLEN'(level), 64'd8);
    chk("ovf_commit_cnt", XLEN'(commit_cnt), 64'd10);
    chk("ovf_drop_cnt", XLEN'(drop_cnt), 64'd2);
    chk("ovf_flag", XLEN'(overflow), 64'd1);
    chk("ovf_head_seq", XLEN'(trace_seq), 64'd0);

    // Full with simultaneous pop and push
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'hB000_0000 + 32'(i), pc, pc + 64'd4, 1'b1, 1'b0);
      pc = pc + 64'd4;
    end
    chk("fullpp_level", XLEN'(level), 64'd8);
    chk("fullpp_drop_cnt", XLEN'(drop_cnt), 64'd2);
    idle(1'b1, DEPTH + 2);

    // Clear mid-stream together with a commit
    do_clear();
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'hC000_0000 + 32'(i), 64'h100 + 64'(4*i), 64'h104 + 64'(4*i), 1'b0, 1'b0);
    chk("clr_level_before", XLEN'(level), 64'd5);
    cyc(1'b1, 32'hDEAD_BEEF, 64'h200, 64'h204, 1'b0, 1'b1);
    chk("clr_valid", XLEN'(trace_valid), '0);
    chk("clr_level", XLEN'(level), '0);
    chk("clr_commit_cnt", XLEN'(commit_cnt), '0);
    cyc(1'b1, 32'hC0DE_0001, 64'h300, 64'h304, 1'b0, 1'b0);
    chk("clr_next_seq", XLEN'(trace_seq), '0);
    idle(1'b1, 3);

    // Randomized traffic with varying consumer throughput
    next_pc = 64'h8000_0000;
    rdy_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rdy_pct = $urandom_range(10, 100);
      if ($urandom_range(0, 3) == 0) pc = {$urandom(), $urandom()};
      else pc = next_pc;
      if ($urandom_range(0, 4) == 0) pre = {$urandom(), $urandom()};
      else pre = pc + 64'd4;
      if ($urandom_range(0, 99) < 70) next_pc = pre;
      cyc(($urandom_range(0, 99) < 70), $urandom(), pc, pre,
          ($urandom_range(0, 99) < rdy_pct), ($urandom_range(0, 149) == 0));
    end
    idle(1'b1, DEPTH + 2);

    // Drop counter saturation and commit counter wrap
    do_clear();
    pc = 64'h9000_0000;
    for (int i = 0; i < 270; i++) begin
      cyc(1'b1, $urandom(), pc, pc + 64'd4, 1'b0, 1'b0);
      pc = pc + 64'd4;
    end
    chk("sat_drop_cnt", XLEN'(drop_cnt), 64'd255);
    chk("sat_commit_cnt", XLEN'(commit_cnt), 64'd14);
    chk("sat_overflow", XLEN'(overflow), 64'd1);
    idle(1'b1, DEPTH + 2);

    chk("scoreboard_drained", XLEN'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
